uart_rx_fifo: RTL and testbench

UART receive stage inside `cpu_top`, directly downstream of the top-level `rx_i` pin and upstream of the CPU peripheral bus. It deserialises 8N1 frames from the asynchronous serial line, checks framing, and buffers received bytes in a first-word-fall-through FIFO. Bytes are handed to the bus-side register logic through a valid/ready handshake.

---
 rtl/uart_rx_fifo.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a first-word-fall-through receive FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        rx_i,
  output logic [7:0]                  data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        frame_err_o,
  output logic                        overrun_o,
  output logic                        parity_err_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP, WAIT_HIGH
  } state_t;

  state_t          state, state_nxt;
  logic            rx_m, rx_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            tick;
  logic            push_req, frame_bad, par_fail;
  logic            push, pop, full;
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_nxt;
  logic [LW-1:0]   level;
  logic [7:0]      mem [FIFO_DEPTH];

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) {rx_s, rx_m} <= 2'b11;
    else        {rx_s, rx_m} <= {rx_m, rx_i};

  assign tick = (cnt == CW'(1));

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!rx_s) state_nxt = START;
      START:     if (tick) state_nxt = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:      if (tick && bit_cnt == 3'd7) state_nxt = PARITY;
      PARITY:    if (tick) state_nxt = STOP;
`else
      DATA:      if (tick && bit_cnt == 3'd7) state_nxt = STOP;
`endif
      STOP:      if (tick) state_nxt = rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i)                       par_bad <= 1'b0;
    else if (state == PARITY && tick) par_bad <= rx_s ^ (^shift);
`else
  logic par_bad;
  assign par_bad = 1'b0;
`endif

  // A bad stop bit masks any parity result.
  always_comb begin
    push_req  = 1'b0;
    frame_bad = 1'b0;
    par_fail  = 1'b0;
    if (state == STOP && tick) begin
      frame_bad = !rx_s;
      push_req  = rx_s && !par_bad;
      par_fail  = rx_s && par_bad;
    end
  end

  // Counter reloads to half a bit while idle so START samples mid-bit.
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i)             cnt <= '0;
    else if (state == IDLE) cnt <= HALF;
    else if (tick)          cnt <= FULL;
    else                    cnt <= cnt - 1'b1;

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      bit_cnt <= '0;
      shift   <= '0;
    end else if (state == START && tick) begin
      bit_cnt <= '0;
    end else if (state == DATA && tick) begin
      shift   <= {rx_s, shift[7:1]};
      bit_cnt <= bit_cnt + 1'b1;
    end

  assign full   = (level == LW'(FIFO_DEPTH));
  assign pop    = valid_o && ready_i;
  assign push   = push_req && (!full || pop);
  assign rd_nxt = rd_ptr + 1'b1;

  always_ff @(posedge clk_i)
    if (push) mem[wr_ptr] <= shift;

  // data_o is the registered head; refresh on push-to-empty or pop.
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      data_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_nxt;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push && level == '0)       data_o <= shift;
      else if (pop && level > LW'(1)) data_o <= mem[rd_nxt];
      else if (pop && push)           data_o <= shift;
    end

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= frame_bad;
      overrun_o   <= push_req && full && !pop;
    end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) parity_err_o <= 1'b0;
    else        parity_err_o <= par_fail;
`else
  assign parity_err_o = 1'b0;
  logic unused_par;
  assign unused_par = par_fail;
`endif

  assign valid_o = (level != '0);
  assign level_o = level;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at CLKS_PER_BIT=16, FIFO_DEPTH=4.
module tb_uart_rx_fifo;
  localparam int C = 16;
  localparam int D = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int PUSH_I = 2 + C/2 + (NB-1)*C;

  logic       clk = 1'b0, rst_i = 1'b0, rx_i = 1'b1, ready_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, overrun_o, parity_err_o;
  logic [2:0] level_o;

  int total = 0, bad = 0;
  int n_fe = 0, n_ov = 0, n_pe = 0, rise = -1;

  uart_rx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst_i), .rx_i(rx_i), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .level_o(level_o), .frame_err_o(frame_err_o),
    .overrun_o(overrun_o), .parity_err_o(parity_err_o));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tally();
    n_fe += int'(frame_err_o);
    n_ov += int'(overrun_o);
    n_pe += int'(parity_err_o);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tally();
    end
  endtask

  // i counts negedges from the start-bit drive; rise = first i with a level change.
  task automatic tx(input logic [7:0] b, input logic stop, input logic par,
                    input int pop_at, input int abort_at);
    logic [2:0] lvl0;
    int k;
    lvl0 = level_o;
    rise = -1;
    for (int i = 0; i < NB*C + 4; i++) begin
      @(negedge clk);
      tally();
      if (rise < 0 && level_o != lvl0) rise = i;
      if (i == abort_at) begin
        rst_i = 1'b0;
        break;
      end
      k = i / C;
      if (k == 0)                    rx_i = 1'b0;
      else if (k <= 8)               rx_i = b[k-1];
      else if (NB == 11 && k == 9)   rx_i = par;
      else if (k == NB-1)            rx_i = stop;
      else                           rx_i = 1'b1;
      ready_i = (i == pop_at);
    end
    rx_i = 1'b1;
    ready_i = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    @(negedge clk);
    chk({tag, "_valid"}, valid_o, 1);
    chk({tag, "_data"}, data_o, exp);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
  endtask

  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_ferr", frame_err_o, 0);
    chk("rst_ovr", overrun_o, 0);
    rst_i = 1'b1;
    idle(5);

    // basic receive and latency
    tx(8'hA5, 1'b1, even_par(8'hA5), -1, -1);
    chk("lat_rise", rise, PUSH_I + 1);
    chk("a5_data", data_o, 8'hA5);
    chk("a5_level", level_o, 1);
    pop_chk("a5_pop", 8'hA5);
    chk("a5_empty", valid_o, 0);

    // short low glitch must not start a frame
    n_fe = 0; n_ov = 0;
    @(negedge clk); rx_i = 1'b0;
    idle(6);
    rx_i = 1'b1;
    idle(30);
    chk("glitch_level", level_o, 0);
    chk("glitch_ferr", n_fe, 0);
    chk("glitch_ovr", n_ov, 0);

    // bad stop bit, then a good frame
    tx(8'h3C, 1'b0, even_par(8'h3C), -1, -1);
    idle(10);
    chk("ferr_pulses", n_fe, 1);
    chk("ferr_level", level_o, 0);
    tx(8'h55, 1'b1, even_par(8'h55), -1, -1);
    idle(4);
    chk("r55_level", level_o, 1);
    pop_chk("r55", 8'h55);

    // fill beyond depth with no consumer
    n_ov = 0;
    for (int j = 1; j <= 5; j++) begin
      tx(8'(j), 1'b1, even_par(8'(j)), -1, -1);
      idle(3);
    end
    chk("ovr_level", level_o, 4);
    chk("ovr_pulses", n_ov, 1);
    for (int j = 1; j <= 4; j++) pop_chk("drain", 8'(j));
    chk("drain_empty", level_o, 0);

    // same, but pop in the cycle 0x05 is pushed
    n_ov = 0;
    for (int j = 1; j <= 4; j++) begin
      tx(8'(j), 1'b1, even_par(8'(j)), -1, -1);
      idle(3);
    end
    tx(8'h05, 1'b1, even_par(8'h05), PUSH_I, -1);
    idle(3);
    chk("popsync_ovr", n_ov, 0);
    chk("popsync_level", level_o, 4);
    for (int j = 2; j <= 5; j++) pop_chk("drain2", 8'(j));

`ifdef UART_RX_PARITY_EN
    n_pe = 0;
    tx(8'h07, 1'b1, 1'b0, -1, -1);
    idle(4);
    chk("par_bad_pulse", n_pe, 1);
    chk("par_bad_level", level_o, 0);
    tx(8'h07, 1'b1, 1'b1, -1, -1);
    idle(4);
    chk("par_ok_level", level_o, 1);
    pop_chk("par_ok", 8'h07);
`endif

    // reset during data bit 4 with two bytes queued
    tx(8'h11, 1'b1, even_par(8'h11), -1, -1);
    idle(3);
    tx(8'h22, 1'b1, even_par(8'h22), -1, -1);
    idle(3);
    chk("pre_rst_level", level_o, 2);
    tx(8'h99, 1'b1, even_par(8'h99), -1, 5*C + 8);
    @(negedge clk);
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_data", data_o, 0);
    chk("mid_rst_level", level_o, 0);
    chk("mid_rst_ferr", frame_err_o, 0);
    chk("mid_rst_perr", parity_err_o, 0);
    idle(3);
    rst_i = 1'b1;
    idle(10);
    tx(8'h81, 1'b1, even_par(8'h81), -1, -1);
    idle(4);
    chk("r81_level", level_o, 1);
    chk("r81_data", data_o, 8'h81);

`ifndef UART_RX_PARITY_EN
    chk("perr_tied", n_pe, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
